// File: rtl/chat_session_ctrl.sv
// Chat terminal session controller: login, password check with lockout,
// message compose/send and receive buffering with LCD refresh strobe.
module chat_session_ctrl #(
  parameter  int NUM_USERS   = 2,
  parameter  int PWD_LEN     = 1,
  parameter  int MSG_CHARS   = 16,
  parameter  int MAX_TRIES   = 3,
  parameter  int LOCK_CYCLES = 50_000_000,
  localparam int UW  = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
  localparam int CW  = $clog2(MSG_CHARS + 1),
  localparam int MB  = MSG_CHARS * 8,
  localparam int PB  = NUM_USERS * PWD_LEN * 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [7:0]    key_ascii,
  input  logic [PB-1:0] pwd_table,
  input  logic          logout,
  input  logic          tx_ready,
  input  logic          rx_valid,
  input  logic [MB-1:0] rx_msg,
  output logic [2:0]    state,
  output logic [UW-1:0] user_id,
  output logic          tx_valid,
  output logic [MB-1:0] tx_msg,
  output logic [MB-1:0] compose_buf,
  output logic [CW-1:0] char_count,
  output logic [MB-1:0] rx_buf,
  output logic          lcd_refresh
);

  localparam int PIW = (PWD_LEN > 1) ? $clog2(PWD_LEN) : 1;
  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int LW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [MB-1:0] SPACES = {MSG_CHARS{8'h20}};

  typedef enum logic [2:0] {
    S_LOGIN    = 3'd0,
    S_PWD      = 3'd1,
    S_COMPOSE  = 3'd2,
    S_SENDING  = 3'd3,
    S_RECEIVED = 3'd4,
    S_LOCKED   = 3'd5
  } state_t;

  state_t          st_q, st_n;
  logic [UW-1:0]   uid_q, uid_n;
  logic            txv_q, txv_n;
  logic [MB-1:0]   txm_q, txm_n;
  logic [MB-1:0]   cbuf_q, cbuf_n;
  logic [CW-1:0]   ccnt_q, ccnt_n;
  logic [MB-1:0]   rbuf_q, rbuf_n;
  logic [PIW-1:0]  pidx_q, pidx_n;
  logic            mm_q, mm_n;
  logic [TW-1:0]   tries_q, tries_n;
  logic            rxp_q, rxp_n;
  logic [LW-1:0]   lcnt_q, lcnt_n;
  logic            chg_q, chg_n;
  logic            lcd_q;
  logic            mm_hit;
  logic [7:0]      pwd_chr;
  logic            is_print, is_bs, is_enter, is_user;

  assign pwd_chr  = pwd_table[(int'(uid_q) * PWD_LEN + int'(pidx_q)) * 8 +: 8];
  assign is_print = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
  assign is_bs    = (key_ascii == 8'h08);
  assign is_enter = (key_ascii == 8'h0D);
  assign is_user  = (key_ascii >= 8'h31) &&
                    (key_ascii <= 8'(8'h30 + NUM_USERS));

  always_comb begin
    st_n    = st_q;
    uid_n   = uid_q;
    txv_n   = txv_q;
    txm_n   = txm_q;
    cbuf_n  = cbuf_q;
    ccnt_n  = ccnt_q;
    rbuf_n  = rbuf_q;
    pidx_n  = pidx_q;
    mm_n    = mm_q;
    tries_n = tries_q;
    rxp_n   = rxp_q;
    lcnt_n  = lcnt_q;
    mm_hit  = 1'b0;
    if (logout && st_q != S_LOCKED) begin
      st_n    = S_LOGIN;
      txv_n   = 1'b0;
      cbuf_n  = SPACES;
      ccnt_n  = '0;
      rxp_n   = 1'b0;
      tries_n = '0;
    end else begin
      unique case (st_q)
        S_LOGIN: begin
          if (key_valid && is_user) begin
            uid_n  = UW'(key_ascii - 8'h31);
            pidx_n = '0;
            mm_n   = 1'b0;
            st_n   = S_PWD;
          end
        end
        S_PWD: begin
          if (key_valid) begin
            if (is_bs) begin
              pidx_n = '0;
              mm_n   = 1'b0;
            end else begin
              mm_hit = mm_q | (key_ascii != pwd_chr);
              if (int'(pidx_q) == PWD_LEN - 1) begin
                pidx_n = '0;
                mm_n   = 1'b0;
                if (!mm_hit) begin
                  st_n    = S_COMPOSE;
                  tries_n = '0;
                end else begin
                  tries_n = tries_q + TW'(1);
                  if (int'(tries_q) + 1 >= MAX_TRIES) begin
                    st_n   = S_LOCKED;
                    lcnt_n = LW'(LOCK_CYCLES - 1);
                  end
                end
              end else begin
                pidx_n = pidx_q + PIW'(1);
                mm_n   = mm_hit;
              end
            end
          end
        end
        S_COMPOSE: begin
          if (key_valid) begin
            if (is_print) begin
              if (ccnt_q < CW'(MSG_CHARS)) begin
                cbuf_n[int'(ccnt_q) * 8 +: 8] = key_ascii;
                ccnt_n = ccnt_q + CW'(1);
              end
            end else if (is_bs) begin
              if (ccnt_q != '0) begin
                ccnt_n = ccnt_q - CW'(1);
                cbuf_n[(int'(ccnt_q) - 1) * 8 +: 8] = 8'h20;
              end
            end else if (is_enter && ccnt_q != '0) begin
              txm_n = cbuf_q;
              txv_n = 1'b1;
              st_n  = S_SENDING;
            end
          end
          // A receive alongside a sending Enter is parked until the handshake
          if (rx_valid) begin
            rbuf_n = rx_msg;
            if (st_n == S_SENDING) rxp_n = 1'b1;
            else                   st_n  = S_RECEIVED;
          end
        end
        S_SENDING: begin
          if (rx_valid) begin
            rbuf_n = rx_msg;
            rxp_n  = 1'b1;
          end
          if (tx_ready) begin
            txv_n  = 1'b0;
            cbuf_n = SPACES;
            ccnt_n = '0;
            st_n   = (rxp_q || rx_valid) ? S_RECEIVED : S_COMPOSE;
          end
        end
        S_RECEIVED: begin
          if (rx_valid) begin
            rbuf_n = rx_msg;
          end else if (key_valid) begin
            st_n  = S_COMPOSE;
            rxp_n = 1'b0;
          end
        end
        S_LOCKED: begin
          if (lcnt_q == '0) begin
            st_n    = S_LOGIN;
            tries_n = '0;
          end else begin
            lcnt_n = lcnt_q - LW'(1);
          end
        end
        default: st_n = S_LOGIN;
      endcase
    end
    chg_n = (st_n != st_q) || (cbuf_n != cbuf_q) || (rbuf_n != rbuf_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= S_LOGIN;
      uid_q   <= '0;
      txv_q   <= 1'b0;
      txm_q   <= SPACES;
      cbuf_q  <= SPACES;
      ccnt_q  <= '0;
      rbuf_q  <= SPACES;
      pidx_q  <= '0;
      mm_q    <= 1'b0;
      tries_q <= '0;
      rxp_q   <= 1'b0;
      lcnt_q  <= '0;
      chg_q   <= 1'b0;
      lcd_q   <= 1'b0;
    end else begin
      st_q    <= st_n;
      uid_q   <= uid_n;
      txv_q   <= txv_n;
      txm_q   <= txm_n;
      cbuf_q  <= cbuf_n;
      ccnt_q  <= ccnt_n;
      rbuf_q  <= rbuf_n;
      pidx_q  <= pidx_n;
      mm_q    <= mm_n;
      tries_q <= tries_n;
      rxp_q   <= rxp_n;
      lcnt_q  <= lcnt_n;
      chg_q   <= chg_n;
      lcd_q   <= chg_q;
    end
  end

  assign state       = st_q;
  assign user_id     = uid_q;
  assign tx_valid    = txv_q;
  assign tx_msg      = txm_q;
  assign compose_buf = cbuf_q;
  assign char_count  = ccnt_q;
  assign rx_buf      = rbuf_q;
  assign lcd_refresh = lcd_q;

endmodule

// File: tb/tb_chat_session_ctrl.sv
// Directed bench for chat_session_ctrl: login, lockout, compose/send,
// receive paths, same-cycle key/rx and logout abort.
module tb_chat_session_ctrl;

  localparam logic [127:0] SP = {16{8'h20}};

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         key_valid = 1'b0;
  logic [7:0]   key_ascii = 8'h00;
  logic [15:0]  pwd_table = {8'h30, 8'h30};
  logic         logout = 1'b0;
  logic         tx_ready = 1'b0;
  logic         rx_valid = 1'b0;
  logic [127:0] rx_msg = SP;
  logic [2:0]   state;
  logic [0:0]   user_id;
  logic         tx_valid;
  logic [127:0] tx_msg;
  logic [127:0] compose_buf;
  logic [4:0]   char_count;
  logic [127:0] rx_buf;
  logic         lcd_refresh;

  int vec = 0;
  int errs = 0;

  chat_session_ctrl #(
    .NUM_USERS(2), .PWD_LEN(1), .MSG_CHARS(16),
    .MAX_TRIES(3), .LOCK_CYCLES(10)
  ) dut (
    .clock(clock), .reset(reset),
    .key_valid(key_valid), .key_ascii(key_ascii),
    .pwd_table(pwd_table), .logout(logout),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_msg(rx_msg),
    .state(state), .user_id(user_id),
    .tx_valid(tx_valid), .tx_msg(tx_msg),
    .compose_buf(compose_buf), .char_count(char_count),
    .rx_buf(rx_buf), .lcd_refresh(lcd_refresh)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input logic [7:0] k);
    key_valid = 1'b1;
    key_ascii = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vec++; if (state !== 3'd0) begin errs++; $display("FAIL rst_state got %0d want 0", state); end
    vec++; if (user_id !== 1'b0) begin errs++; $display("FAIL rst_uid got %0d want 0", user_id); end
    vec++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL rst_txv got %b want 0", tx_valid); end
    vec++; if (tx_msg !== SP) begin errs++; $display("FAIL rst_txmsg got %h want %h", tx_msg, SP); end
    vec++; if (compose_buf !== SP) begin errs++; $display("FAIL rst_cbuf got %h want %h", compose_buf, SP); end
    vec++; if (rx_buf !== SP) begin errs++; $display("FAIL rst_rbuf got %h want %h", rx_buf, SP); end
    vec++; if (char_count !== 5'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", char_count); end
    vec++; if (lcd_refresh !== 1'b0) begin errs++; $display("FAIL rst_lcd got %b want 0", lcd_refresh); end
  endtask

  task automatic test_login();
    int p;
    key(8'h39);
    key(8'h33);
    key(8'h30);
    tick();
    vec++; if (state !== 3'd0) begin errs++; $display("FAIL login_ignore got %0d want 0", state); end
    vec++; if (lcd_refresh !== 1'b0) begin errs++; $display("FAIL login_nolcd got %b want 0", lcd_refresh); end
    key(8'h31);
    vec++; if (state !== 3'd1) begin errs++; $display("FAIL login_pwd got %0d want 1", state); end
    vec++; if (user_id !== 1'b0) begin errs++; $display("FAIL login_uid got %0d want 0", user_id); end
    p = 0;
    for (int i = 0; i < 4; i++) begin
      if (lcd_refresh === 1'b1) p++;
      if (i < 3) tick();
    end
    vec++; if (p != 1) begin errs++; $display("FAIL login_lcd1 got %0d pulses want 1", p); end
    key(8'h30);
    vec++; if (state !== 3'd2) begin errs++; $display("FAIL login_compose got %0d want 2", state); end
    p = 0;
    for (int i = 0; i < 4; i++) begin
      if (lcd_refresh === 1'b1) p++;
      if (i < 3) tick();
    end
    vec++; if (p != 1) begin errs++; $display("FAIL login_lcd2 got %0d pulses want 1", p); end
  endtask

  task automatic test_lockout();
    logout = 1'b1;
    tick();
    logout = 1'b0;
    vec++; if (state !== 3'd0) begin errs++; $display("FAIL lock_logout got %0d want 0", state); end
    key(8'h32);
    vec++; if (state !== 3'd1 || user_id !== 1'b1) begin errs++; $display("FAIL lock_user2 got st %0d uid %0d want 1/1", state, user_id); end
    key(8'h35);
    key(8'h08);
    key(8'h35);
    vec++; if (state !== 3'd1) begin errs++; $display("FAIL lock_try2 got %0d want 1", state); end
    key(8'h35);
    vec++; if (state !== 3'd5) begin errs++; $display("FAIL lock_enter got %0d want 5", state); end
    for (int i = 1; i <= 9; i++) begin
      if (i % 2 == 0) begin key_valid = 1'b1; key_ascii = 8'h31; end
      else logout = 1'b1;
      tick();
      key_valid = 1'b0;
      logout = 1'b0;
      vec++; if (state !== 3'd5) begin errs++; $display("FAIL lock_hold%0d got %0d want 5", i, state); end
    end
    tick();
    vec++; if (state !== 3'd0) begin errs++; $display("FAIL lock_expire got %0d want 0", state); end
    key(8'h32);
    key(8'h35);
    key(8'h30);
    vec++; if (state !== 3'd2) begin errs++; $display("FAIL lock_relogin got %0d want 2", state); end
  endtask

  task automatic test_compose_send();
    logic [127:0] exp;
    key(8'h0D);
    vec++; if (state !== 3'd2) begin errs++; $display("FAIL cmp_empty_enter got %0d want 2", state); end
    for (int i = 0; i < 17; i++) key(8'h41);
    vec++; if (char_count !== 5'd16) begin errs++; $display("FAIL cmp_full got %0d want 16", char_count); end
    vec++; if (compose_buf !== {16{8'h41}}) begin errs++; $display("FAIL cmp_fullbuf got %h", compose_buf); end
    key(8'h08);
    key(8'h08);
    key(8'h01);
    vec++; if (char_count !== 5'd14) begin errs++; $display("FAIL cmp_bs got %0d want 14", char_count); end
    exp = {{2{8'h20}}, {14{8'h41}}};
    vec++; if (compose_buf !== exp) begin errs++; $display("FAIL cmp_bsbuf got %h want %h", compose_buf, exp); end
    key(8'h0D);
    vec++; if (state !== 3'd3 || tx_valid !== 1'b1) begin errs++; $display("FAIL cmp_send got st %0d txv %b want 3/1", state, tx_valid); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin key_valid = 1'b1; key_ascii = 8'h42; end
      tick();
      key_valid = 1'b0;
      vec++; if (tx_valid !== 1'b1 || tx_msg !== exp || state !== 3'd3) begin errs++; $display("FAIL cmp_hold%0d got txv %b st %0d msg %h want %h", i, tx_valid, state, tx_msg, exp); end
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    vec++; if (state !== 3'd2 || tx_valid !== 1'b0) begin errs++; $display("FAIL cmp_hs got st %0d txv %b want 2/0", state, tx_valid); end
    vec++; if (char_count !== 5'd0 || compose_buf !== SP) begin errs++; $display("FAIL cmp_clear got cnt %0d buf %h", char_count, compose_buf); end
  endtask

  task automatic test_rx_sending();
    logic [127:0] m1;
    m1 = "MSG-ONE-ABCDEFGH";
    key(8'h68);
    key(8'h69);
    key(8'h0D);
    rx_valid = 1'b1;
    rx_msg = m1;
    tick();
    rx_valid = 1'b0;
    vec++; if (rx_buf !== m1 || state !== 3'd3) begin errs++; $display("FAIL rxs_load got st %0d buf %h want 3 %h", state, rx_buf, m1); end
    vec++; if (tx_valid !== 1'b1) begin errs++; $display("FAIL rxs_txv got %b want 1", tx_valid); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    vec++; if (state !== 3'd4 || tx_valid !== 1'b0) begin errs++; $display("FAIL rxs_recv got st %0d txv %b want 4/0", state, tx_valid); end
    key(8'h7A);
    vec++; if (state !== 3'd2 || char_count !== 5'd0) begin errs++; $display("FAIL rxs_back got st %0d cnt %0d want 2/0", state, char_count); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] m2, m3, exp;
    m2 = "second-message!!";
    m3 = "third message 33";
    exp = SP;
    exp[7:0] = 8'h61;
    exp[15:8] = 8'h78;
    key(8'h61);
    key_valid = 1'b1;
    key_ascii = 8'h78;
    rx_valid = 1'b1;
    rx_msg = m2;
    tick();
    key_valid = 1'b0;
    rx_valid = 1'b0;
    vec++; if (state !== 3'd4 || char_count !== 5'd2) begin errs++; $display("FAIL b2b_state got st %0d cnt %0d want 4/2", state, char_count); end
    vec++; if (compose_buf !== exp || rx_buf !== m2) begin errs++; $display("FAIL b2b_bufs got %h %h want %h %h", compose_buf, rx_buf, exp, m2); end
    rx_valid = 1'b1;
    rx_msg = m3;
    tick();
    rx_valid = 1'b0;
    vec++; if (state !== 3'd4 || rx_buf !== m3) begin errs++; $display("FAIL b2b_over got st %0d buf %h want 4 %h", state, rx_buf, m3); end
    key(8'h71);
    vec++; if (state !== 3'd2 || compose_buf !== exp || char_count !== 5'd2) begin errs++; $display("FAIL b2b_keep got st %0d cnt %0d buf %h", state, char_count, compose_buf); end
    key(8'h0D);
    vec++; if (state !== 3'd3 || tx_valid !== 1'b1) begin errs++; $display("FAIL b2b_send got st %0d txv %b want 3/1", state, tx_valid); end
    logout = 1'b1;
    tick();
    logout = 1'b0;
    vec++; if (state !== 3'd0 || tx_valid !== 1'b0) begin errs++; $display("FAIL b2b_abort got st %0d txv %b want 0/0", state, tx_valid); end
    vec++; if (compose_buf !== SP || char_count !== 5'd0) begin errs++; $display("FAIL b2b_clr got cnt %0d buf %h", char_count, compose_buf); end
  endtask

  task automatic test_reset_sending();
    key(8'h31);
    key(8'h30);
    key(8'h55);
    key(8'h0D);
    vec++; if (tx_valid !== 1'b1) begin errs++; $display("FAIL rsts_pre got %b want 1", tx_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vec++; if (tx_valid !== 1'b0 || state !== 3'd0) begin errs++; $display("FAIL rsts_drop got txv %b st %0d want 0/0", tx_valid, state); end
  endtask

  initial begin
    test_reset();
    test_login();
    test_lockout();
    test_compose_send();
    test_rx_sending();
    test_back_to_back();
    test_reset_sending();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
